// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit/receive paths.
//   - LCR field bit positions
//   - parity-mode encodings for lcr[5:3]
//   - transmitter state enum
//   - TICKS_PER_BIT (baud ticks per serial bit)
//   - helpers: word-length mask and parity-bit computation
package uart_pkg;

  localparam int LCR_WLS_LSB = 0;  // [1:0] word length 5/6/7/8
  localparam int LCR_STB     = 2;  // stop bits select
  localparam int LCR_PEN     = 3;  // parity enable
  localparam int LCR_EPS     = 4;  // even parity select
  localparam int LCR_SP      = 5;  // stick parity
  localparam int LCR_BRK     = 6;  // break control
  localparam int LCR_DLAB    = 7;  // divisor latch access, unused by tx

  localparam logic [2:0] PAR_ODD   = 3'b001;
  localparam logic [2:0] PAR_EVEN  = 3'b011;
  localparam logic [2:0] PAR_MARK  = 3'b101;
  localparam logic [2:0] PAR_SPACE = 3'b111;

  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Keeps only the data bits that belong to the selected word length.
  function automatic logic [7:0] word_mask(input logic [1:0] wls);
    logic [7:0] m;
    case (wls)
      2'b00:   m = 8'h1F;
      2'b01:   m = 8'h3F;
      2'b10:   m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Parity bit for a frame; only meaningful when parity is enabled.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] wls,
                                      input logic [2:0] mode);
    logic x;
    logic p;
    x = ^(data & word_mask(wls));
    case (mode)
      PAR_ODD:   p = ~x;
      PAR_EVEN:  p = x;
      PAR_MARK:  p = 1'b1;
      PAR_SPACE: p = 1'b0;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divisor counter producing one baud tick every D clocks.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   restart  in   zero the counter (frame start)
//   divisor  in   16-bit divisor D; D=0 behaves as D=1
//   tick     out  one-cycle tick, decoded from the counter register
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] r_cnt;
  logic [15:0] w_last;

  assign w_last = (divisor == 16'd0) ? 16'd0 : (divisor - 16'd1);
  // '>=' so a divisor lowered below the running count still wraps promptly.
  assign tick   = (r_cnt >= w_last);

  // Divisor counter: wraps on each tick, zeroed on restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (restart || tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter with a one-entry holding register (THR).
// Frame: start, 5-8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
// Format is latched from lcr at each frame start; bit time is 16*D clocks.
//   clk, rst           clock, synchronous active-high reset
//   lcr, dll, dlh      line control and baud divisor {dlh,dll}
//   thr_data, thr_wr   byte to send and its one-cycle write strobe
//   thre_ie            THR-empty interrupt enable
//   tx                 serial line (registered, idles high)
//   thr_empty          THRE; tx_empty: TEMT (idle and THR empty)
//   thr_ovr            one-cycle pulse when a write is dropped
//   intt_tx            registered thr_empty & thre_ie
// Build option: define UART_TX_BREAK_EN to let lcr[6] force tx low.
module uart_tx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lcr,
  input  logic [7:0] dll,
  input  logic [7:0] dlh,
  input  logic [7:0] thr_data,
  input  logic       thr_wr,
  input  logic       thre_ie,
  output logic       tx,
  output logic       thr_empty,
  output logic       tx_empty,
  output logic       thr_ovr,
  output logic       intt_tx
);

  localparam logic [4:0] TICK_LAST = 5'(TICKS_PER_BIT - 1);

  tx_state_t  r_state;
  logic [7:0] r_thr;
  logic [7:0] r_shift;
  logic [3:0] r_fmt;      // latched lcr[3:0]: word length, stop, parity enable
  logic       r_thr_full;
  logic       r_par;
  logic       r_line;     // current bit value without break applied
  logic       r_tx;
  logic       r_thr_ovr;
  logic       r_intt;
  logic [4:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;

  logic       w_tick;
  logic       w_load;
  logic       w_brk;
  logic       w_tick_end;
  logic       w_stop_end;
  logic [4:0] w_stop_last;
  logic [2:0] w_last_bit;
  logic       w_unused_lcr;

`ifdef UART_TX_BREAK_EN
  assign w_brk = lcr[LCR_BRK];
`else
  assign w_brk = 1'b0;
`endif
  assign w_unused_lcr = ^lcr[LCR_DLAB:LCR_BRK];

  uart_baud_gen u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (w_load),
    .divisor ({dlh, dll}),
    .tick    (w_tick)
  );

  // Stop length in ticks minus one: 16, or 32 (24 for a 5-bit word).
  always_comb begin
    w_stop_last = TICK_LAST;
    if (r_fmt[LCR_STB]) begin
      if (r_fmt[1:0] == 2'b00) begin
        w_stop_last = 5'd23;
      end else begin
        w_stop_last = 5'd31;
      end
    end else begin
      w_stop_last = TICK_LAST;
    end
  end

  assign w_last_bit = 3'd4 + {1'b0, r_fmt[1:0]};
  assign w_tick_end = w_tick && (r_tick_cnt == TICK_LAST);
  assign w_stop_end = (r_state == TX_STOP) && w_tick && (r_tick_cnt == w_stop_last);
  // Transfer THR to the shifter from idle, or straight out of the stop bit.
  assign w_load     = r_thr_full && ((r_state == TX_IDLE) || w_stop_end);

  // Holding register, overrun pulse and THR-empty interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_thr      <= 8'd0;
      r_thr_full <= 1'b0;
      r_thr_ovr  <= 1'b0;
      r_intt     <= 1'b0;
    end else begin
      r_thr_ovr <= 1'b0;
      r_intt    <= ~r_thr_full & thre_ie;
      // A write on the transfer cycle refills THR behind the transfer.
      if (thr_wr && (!r_thr_full || w_load)) begin
        r_thr      <= thr_data;
        r_thr_full <= 1'b1;
      end else if (thr_wr) begin
        r_thr_ovr <= 1'b1;
      end else if (w_load) begin
        r_thr_full <= 1'b0;
      end else begin
        r_thr_full <= r_thr_full;
      end
    end
  end

  // Frame state machine and registered serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= TX_IDLE;
      r_shift    <= 8'd0;
      r_fmt      <= 4'd0;
      r_par      <= 1'b0;
      r_tick_cnt <= 5'd0;
      r_bit_cnt  <= 3'd0;
      r_line     <= 1'b1;
      r_tx       <= 1'b1;
    end else begin
      r_tx <= r_line;
      if (w_load) begin
        r_state    <= TX_START;
        r_shift    <= r_thr;
        r_fmt      <= lcr[3:0];
        r_par      <= parity_bit(r_thr, lcr[1:0], lcr[LCR_SP:LCR_PEN]);
        r_tick_cnt <= 5'd0;
        r_bit_cnt  <= 3'd0;
        r_line     <= 1'b0;
        r_tx       <= 1'b0;
      end else if (w_tick) begin
        case (r_state)
          TX_IDLE: begin
            r_tick_cnt <= 5'd0;
          end
          TX_START: begin
            if (w_tick_end) begin
              r_state    <= TX_DATA;
              r_tick_cnt <= 5'd0;
              r_line     <= r_shift[0];
              r_tx       <= r_shift[0];
            end else begin
              r_tick_cnt <= r_tick_cnt + 5'd1;
            end
          end
          TX_DATA: begin
            if (w_tick_end) begin
              r_tick_cnt <= 5'd0;
              if (r_bit_cnt == w_last_bit) begin
                if (r_fmt[LCR_PEN]) begin
                  r_state <= TX_PARITY;
                  r_line  <= r_par;
                  r_tx    <= r_par;
                end else begin
                  r_state <= TX_STOP;
                  r_line  <= 1'b1;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {1'b0, r_shift[7:1]};
                r_line    <= r_shift[1];
                r_tx      <= r_shift[1];
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 5'd1;
            end
          end
          TX_PARITY: begin
            if (w_tick_end) begin
              r_state    <= TX_STOP;
              r_tick_cnt <= 5'd0;
              r_line     <= 1'b1;
              r_tx       <= 1'b1;
            end else begin
              r_tick_cnt <= r_tick_cnt + 5'd1;
            end
          end
          TX_STOP: begin
            if (r_tick_cnt == w_stop_last) begin
              r_state    <= TX_IDLE;
              r_tick_cnt <= 5'd0;
            end else begin
              r_tick_cnt <= r_tick_cnt + 5'd1;
            end
          end
          default: begin
            r_state    <= TX_IDLE;
            r_tick_cnt <= 5'd0;
            r_line     <= 1'b1;
            r_tx       <= 1'b1;
          end
        endcase
      end
      // Break overrides the line; the frame keeps advancing underneath.
      if (w_brk) begin
        r_tx <= 1'b0;
      end
    end
  end

  assign tx        = r_tx;
  assign thr_empty = ~r_thr_full;
  assign tx_empty  = (r_state == TX_IDLE) & ~r_thr_full;
  assign thr_ovr   = r_thr_ovr;
  assign intt_tx   = r_intt;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line levels per clock are queued
// when a byte is written and compared cycle by cycle by a line monitor.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] lcr = 8'h03;
  logic [7:0] dll = 8'h01;
  logic [7:0] dlh = 8'h00;
  logic [7:0] thr_data = 8'h00;
  logic       thr_wr = 1'b0;
  logic       thre_ie = 1'b0;
  logic       tx, thr_empty, tx_empty, thr_ovr, intt_tx;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mon_rem = 0;
  logic flush = 1'b0;
  logic q_lvl[$];
  int   q_len[$];
  int   t0;

  uart_tx dut (
    .clk       (clk),
    .rst       (rst),
    .lcr       (lcr),
    .dll       (dll),
    .dlh       (dlh),
    .thr_data  (thr_data),
    .thr_wr    (thr_wr),
    .thre_ie   (thre_ie),
    .tx        (tx),
    .thr_empty (thr_empty),
    .tx_empty  (tx_empty),
    .thr_ovr   (thr_ovr),
    .intt_tx   (intt_tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected line level for every clock of one frame.
  task automatic push_frame(input logic [7:0] d, input logic [7:0] l, input int div);
    int   bl, nb, ones, stop, total;
    logic p;
    bl    = 16 * ((div == 0) ? 1 : div);
    nb    = 5 + int'(l[1:0]);
    ones  = 0;
    total = 0;
    for (int k = 0; k < bl; k++) q_lvl.push_back(1'b0);
    total += bl;
    for (int i = 0; i < nb; i++) begin
      if (d[i]) ones++;
      for (int k = 0; k < bl; k++) q_lvl.push_back(d[i]);
      total += bl;
    end
    if (l[3]) begin
      case (l[5:4])
        2'b00:   p = ((ones % 2) == 0);
        2'b01:   p = ((ones % 2) == 1);
        2'b10:   p = 1'b1;
        default: p = 1'b0;
      endcase
      for (int k = 0; k < bl; k++) q_lvl.push_back(p);
      total += bl;
    end
    stop = l[2] ? ((nb == 5) ? (bl * 3) / 2 : 2 * bl) : bl;
    for (int k = 0; k < stop; k++) q_lvl.push_back(1'b1);
    total += stop;
    q_len.push_back(total);
  endtask

  // Compares tx against the queued levels, starting at each falling edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (flush) begin
        q_lvl.delete();
        q_len.delete();
        mon_rem = 0;
      end else if (mon_rem > 0) begin
        check("tx_bit", tx, q_lvl.pop_front());
        mon_rem--;
      end else if (tx === 1'b0) begin
        if (q_len.size() == 0) begin
          check("unexpected_start", tx, 1'b1);
        end else begin
          mon_rem = q_len.pop_front();
          check("tx_bit", tx, q_lvl.pop_front());
          mon_rem--;
        end
      end
    end
  endtask

  // Called just after a clock edge; the strobe is sampled at the next edge.
  task automatic wr(input logic [7:0] d);
    thr_data = d;
    thr_wr   = 1'b1;
    @(posedge clk); #1;
    thr_wr   = 1'b0;
  endtask

  task automatic wait_temt(input int start, input int exp_cycles);
    int n;
    n = 0;
    while (tx_empty !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("temt_timeout", tx_empty, 1'b1);
    check("frame_cycles", cyc - start, exp_cycles);
    check("sb_drained", q_len.size() + mon_rem, 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    thre_ie = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_thr_empty", thr_empty, 1'b1);
    check("rst_tx_empty", tx_empty, 1'b1);
    check("rst_thr_ovr", thr_ovr, 1'b0);
    check("rst_intt", intt_tx, 1'b0);
    rst = 1'b0;
    thre_ie = 1'b0;
    @(posedge clk); #1;

    // 8 data bits, odd parity, D=2
    lcr = 8'h8B; dll = 8'h02; dlh = 8'h00;
    push_frame(8'h55, 8'h8B, 2);
    wr(8'h55);
    t0 = cyc;
    check("wr_thr_empty", thr_empty, 1'b0);
    check("wr_tx_empty", tx_empty, 1'b0);
    @(posedge clk); #1;
    check("xfer_thr_empty", thr_empty, 1'b1);
    check("start_bit", tx, 1'b0);
    wait_temt(t0, 1 + 352);

    // Back-to-back frames, 8N1, D=1, interrupt enabled
    lcr = 8'h03; dll = 8'h01; thre_ie = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("intt_idle", intt_tx, 1'b1);
    push_frame(8'hA5, 8'h03, 1);
    wr(8'hA5);
    t0 = cyc;
    @(posedge clk); #1;
    check("intt_fall_1", intt_tx, 1'b0);
    check("thr_empty_again", thr_empty, 1'b1);
    push_frame(8'h3C, 8'h03, 1);
    wr(8'h3C);
    @(posedge clk); #1;
    check("intt_fall_2", intt_tx, 1'b0);
    wait_temt(t0, 1 + 320);
    check("intt_end", intt_tx, 1'b1);
    thre_ie = 1'b0;

    // 5-bit word, even parity, 1.5 stop bits
    lcr = 8'h1C;
    push_frame(8'h07, 8'h1C, 1);
    wr(8'h07);
    t0 = cyc;
    wait_temt(t0, 1 + 136);

    // Refill on transfer cycle, then a dropped write
    lcr = 8'h03;
    push_frame(8'h11, 8'h03, 1);
    wr(8'h11);
    t0 = cyc;
    push_frame(8'h22, 8'h03, 1);
    wr(8'h22);
    check("refill_thr_empty", thr_empty, 1'b0);
    check("refill_no_ovr", thr_ovr, 1'b0);
    wr(8'h33);
    check("ovr_pulse", thr_ovr, 1'b1);
    @(posedge clk); #1;
    check("ovr_one_cycle", thr_ovr, 1'b0);
    wait_temt(t0, 1 + 320);

    // Divisor zero behaves as one
    dll = 8'h00; dlh = 8'h00;
    push_frame(8'h81, 8'h03, 0);
    wr(8'h81);
    t0 = cyc;
    wait_temt(t0, 1 + 160);
    dll = 8'h01;

    // Break request during a frame
`ifdef UART_TX_BREAK_EN
    flush = 1'b1;
    wr(8'hFF);
    t0 = cyc;
    repeat (20) begin @(posedge clk); #1; end
    lcr = 8'h43;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("break_low", tx, 1'b0);
    end
    lcr = 8'h03;
    @(posedge clk); #1;
    check("break_release", tx, 1'b1);
    wait_temt(t0, 1 + 160);
    flush = 1'b0;
`else
    push_frame(8'hFF, 8'h03, 1);
    wr(8'hFF);
    t0 = cyc;
    repeat (20) begin @(posedge clk); #1; end
    lcr = 8'h43;
    repeat (100) begin @(posedge clk); #1; end
    lcr = 8'h03;
    wait_temt(t0, 1 + 160);
`endif

    // Reset in the middle of a data bit
    dll = 8'h04;
    push_frame(8'h00, 8'h03, 4);
    wr(8'h00);
    repeat (200) begin @(posedge clk); #1; end
    check("pre_reset_low", tx, 1'b0);
    rst = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_thr_empty", thr_empty, 1'b1);
    check("midrst_tx_empty", tx_empty, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (700) begin @(posedge clk); #1; end
    check("post_rst_idle_tx", tx, 1'b1);
    check("post_rst_tx_empty", tx_empty, 1'b1);
    check("post_rst_sb", q_len.size() + mon_rem, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
